// File: rtl/fp_normalizer_pipe.sv
// Three-stage floating-point normaliser: leading-zero count, exponent-limited
// left shift, and exponent adjust, with a valid/ready handshake and bubble collapsing.
module fp_normalizer_pipe #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [DATA_W-1:0]           mant_i,
  input  logic [EXP_W-1:0]            exp_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [DATA_W-1:0]           mant_o,
  output logic [EXP_W-1:0]            exp_o,
  output logic [$clog2(DATA_W)-1:0]   shift_o,
  output logic                        zero_o,
  output logic                        uflow_o
);

  localparam int LZ_W  = $clog2(DATA_W);
  localparam int NIB_N = DATA_W / 4;
  localparam int NIB_W = LZ_W - 2;
  localparam int CMP_W = (LZ_W > EXP_W) ? LZ_W : EXP_W;

  logic              s1_load, s2_load, s3_load;

  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_mant_q;
  logic [EXP_W-1:0]  s1_exp_q;

  logic              s2_valid_q;
  logic [DATA_W-1:0] s2_mant_q;
  logic [EXP_W-1:0]  s2_exp_q;
  logic [LZ_W-1:0]   s2_lz_q, s2_lz_d;
  logic              s2_zero_q, s2_zero_d;

  logic              out_valid_q;
  logic [DATA_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [LZ_W-1:0]   shift_q, shift_d;
  logic              zero_q, zero_d;
  logic              uflow_q, uflow_d;

  // A stage loads when it is empty or its downstream stage loads this cycle.
  assign s3_load    = !out_valid_q | out_ready_i;
  assign s2_load    = !s2_valid_q | s3_load;
  assign s1_load    = !s1_valid_q | s2_load;
  assign in_ready_o = s1_load;

  // NOTE: data registers are reset along with the valid bits so every output
  // reads zero during reset; they still load only when their stage loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mant_q  <= '0;
      s1_exp_q   <= '0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid_i;
      s1_mant_q  <= mant_i;
      s1_exp_q   <= exp_i;
    end
  end

  logic [NIB_W-1:0] nib_idx;
  logic [3:0]       nib_sel;
  logic [1:0]       nib_lz;
  logic             any_nz;

  // NOTE: every variable gets a default before the loop and case, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    nib_idx = '0;
    nib_sel = '0;
    any_nz  = 1'b0;
    // Scan from the least significant nibble up; the last hit is the leading one.
    for (int k = NIB_N - 1; k >= 0; k--) begin
      if (|s1_mant_q[DATA_W-1-4*k -: 4]) begin
        nib_idx = NIB_W'(k);
        nib_sel = s1_mant_q[DATA_W-1-4*k -: 4];
        any_nz  = 1'b1;
      end
    end
    casez (nib_sel)
      4'b1???: nib_lz = 2'd0;
      4'b01??: nib_lz = 2'd1;
      4'b001?: nib_lz = 2'd2;
      default: nib_lz = 2'd3;
    endcase
    s2_zero_d = !any_nz;
    s2_lz_d   = any_nz ? {nib_idx, nib_lz} : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_mant_q  <= '0;
      s2_exp_q   <= '0;
      s2_lz_q    <= '0;
      s2_zero_q  <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      s2_mant_q  <= s1_mant_q;
      s2_exp_q   <= s1_exp_q;
      s2_lz_q    <= s2_lz_d;
      s2_zero_q  <= s2_zero_d;
    end
  end

  logic [CMP_W-1:0]  lz_ext, exp_ext;
  logic [LZ_W-1:0]   sh;
  logic              sh_limited;
  logic [DATA_W-1:0] shifted;

  always_comb begin
    lz_ext  = CMP_W'(s2_lz_q);
    exp_ext = CMP_W'(s2_exp_q);
    // When lz exceeds exp, exp < DATA_W, so it fits in the shift-count width.
    if (lz_ext <= exp_ext) begin
      sh         = s2_lz_q;
      sh_limited = 1'b0;
    end else begin
      sh         = LZ_W'(s2_exp_q);
      sh_limited = 1'b1;
    end

    shifted = s2_mant_q;
    for (int i = 0; i < LZ_W; i++) begin
      if (sh[i]) shifted = shifted << (1 << i);
    end

    mant_d  = shifted;
    exp_d   = EXP_W'(exp_ext - CMP_W'(sh));
    shift_d = sh;
    zero_d  = 1'b0;
    uflow_d = sh_limited;
    if (s2_zero_q) begin
      mant_d  = '0;
      exp_d   = '0;
      shift_d = '0;
      zero_d  = 1'b1;
      uflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      mant_q      <= '0;
      exp_q       <= '0;
      shift_q     <= '0;
      zero_q      <= 1'b0;
      uflow_q     <= 1'b0;
    end else if (s3_load) begin
      out_valid_q <= s2_valid_q;
      mant_q      <= mant_d;
      exp_q       <= exp_d;
      shift_q     <= shift_d;
      zero_q      <= zero_d;
      uflow_q     <= uflow_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign mant_o      = mant_q;
  assign exp_o       = exp_q;
  assign shift_o     = shift_q;
  assign zero_o      = zero_q;
  assign uflow_o     = uflow_q;

endmodule

// File: tb/tb_fp_normalizer_pipe.sv
// Directed bench for fp_normalizer_pipe: 16-bit handshake/latency/reset checks
// plus single-bit sweeps on 32- and 64-bit instances.
module tb_fp_normalizer_pipe;

  logic clk;
  logic rst_n;

  // 16-bit instance
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_zero, a_uflow;
  logic [15:0] a_mant_i, a_mant_o;
  logic [4:0]  a_exp_i, a_exp_o;
  logic [3:0]  a_shift;
  logic [26:0] a_obs;

  // 32-bit instance
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_zero, b_uflow;
  logic [31:0] b_mant_i, b_mant_o;
  logic [7:0]  b_exp_i, b_exp_o;
  logic [4:0]  b_shift;

  // 64-bit instance
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_zero, c_uflow;
  logic [63:0] c_mant_i, c_mant_o;
  logic [7:0]  c_exp_i, c_exp_o;
  logic [5:0]  c_shift;

  int n_total = 0;
  int n_bad   = 0;

  fp_normalizer_pipe #(.DATA_W(16), .EXP_W(5)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .mant_i(a_mant_i), .exp_i(a_exp_i),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .mant_o(a_mant_o), .exp_o(a_exp_o), .shift_o(a_shift),
    .zero_o(a_zero), .uflow_o(a_uflow)
  );

  fp_normalizer_pipe #(.DATA_W(32), .EXP_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .mant_i(b_mant_i), .exp_i(b_exp_i),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .mant_o(b_mant_o), .exp_o(b_exp_o), .shift_o(b_shift),
    .zero_o(b_zero), .uflow_o(b_uflow)
  );

  fp_normalizer_pipe #(.DATA_W(64), .EXP_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(c_in_valid), .in_ready_o(c_in_ready),
    .mant_i(c_mant_i), .exp_i(c_exp_i),
    .out_valid_o(c_out_valid), .out_ready_i(c_out_ready),
    .mant_o(c_mant_o), .exp_o(c_exp_o), .shift_o(c_shift),
    .zero_o(c_zero), .uflow_o(c_uflow)
  );

  assign a_obs = {a_mant_o, a_exp_o, a_shift, a_zero, a_uflow};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: shift one bit at a time while the exponent allows it.
  function automatic logic [26:0] model16(input logic [15:0] m, input logic [4:0] e);
    logic [15:0] mm;
    logic [4:0]  ee;
    logic [3:0]  s;
    if (m == 16'h0) return {16'h0, 5'd0, 4'd0, 1'b1, 1'b0};
    mm = m; ee = e; s = 4'd0;
    while (!mm[15] && ee != 5'd0) begin
      mm = mm << 1;
      ee = ee - 5'd1;
      s  = s + 4'd1;
    end
    return {mm, ee, s, 1'b0, !mm[15]};
  endfunction

  // Entered and left just after a rising edge; checks exact 3-cycle latency.
  task automatic run16(input string tag, input logic [15:0] m, input logic [4:0] e,
                       input logic [26:0] exp_obs);
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_mant_i    = m;
    a_exp_i     = e;
    #1;
    check({tag, "_rdy"}, a_in_ready, 1'b1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    check({tag, "_lat1"}, a_out_valid, 1'b0);
    @(posedge clk); #1;
    check({tag, "_lat2"}, a_out_valid, 1'b0);
    @(posedge clk); #1;
    check({tag, "_vld"}, a_out_valid, 1'b1);
    check({tag, "_data"}, a_obs, exp_obs);
    @(posedge clk); #1;
    check({tag, "_gone"}, a_out_valid, 1'b0);
  endtask

  logic [15:0] vm [8];
  logic [4:0]  ve [8];

  initial begin
    logic [26:0] expq[$];
    logic [26:0] snap;
    logic        held, acc, ret;
    int          sent, got, occ;

    vm = '{16'h0001, 16'h0010, 16'h8000, 16'h0000, 16'h00F0, 16'h0300, 16'h1234, 16'h4000};
    ve = '{5'd20,    5'd3,     5'd7,     5'd9,     5'd31,    5'd2,     5'd0,     5'd1};

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_mant_i = '0; a_exp_i = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_mant_i = '0; b_exp_i = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_mant_i = '0; c_exp_i = '0; c_out_ready = 1'b1;

    #2;
    check("rst_vld", a_out_valid, 1'b0);
    check("rst_obs", a_obs, 27'h0);
    check("rst_rdy", a_in_ready, 1'b1);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed single operands, hand-computed results {mant, exp, shift, zero, uflow}
    run16("d_lsb",    16'h0001, 5'd20, {16'h8000, 5'd5,  4'd15, 1'b0, 1'b0});
    run16("d_uflow",  16'h0010, 5'd3,  {16'h0080, 5'd0,  4'd3,  1'b0, 1'b1});
    run16("d_norm",   16'h8000, 5'd7,  {16'h8000, 5'd7,  4'd0,  1'b0, 1'b0});
    run16("d_zero",   16'h0000, 5'd9,  {16'h0000, 5'd0,  4'd0,  1'b1, 1'b0});
    run16("d_eq",     16'h0001, 5'd15, {16'h8000, 5'd0,  4'd15, 1'b0, 1'b0});
    run16("d_exp0",   16'h00A0, 5'd0,  {16'h00A0, 5'd0,  4'd0,  1'b0, 1'b1});
    run16("d_norm0",  16'h8000, 5'd0,  {16'h8000, 5'd0,  4'd0,  1'b0, 1'b0});

    // Back-to-back stream against a stall pattern with 5 consecutive low cycles
    sent = 0; got = 0; occ = 0; held = 1'b0; snap = '0;
    for (int t = 0; t < 80 && got < 8; t++) begin
      a_out_ready = !((t >= 4 && t <= 8) || t == 11 || t == 14 || t == 15);
      a_in_valid  = (sent < 8);
      if (sent < 8) begin
        a_mant_i = vm[sent];
        a_exp_i  = ve[sent];
      end
      #1;
      check("s_in_ready", a_in_ready, (occ < 3) || a_out_ready);
      if (held) check("s_stable", {a_out_valid, a_obs}, {1'b1, snap});
      if (a_out_valid && a_out_ready) begin
        if (expq.size() == 0) begin
          check("s_extra", a_out_valid, 1'b0);
        end else begin
          check("s_data", a_obs, expq.pop_front());
          got++;
        end
      end
      held = a_out_valid && !a_out_ready;
      snap = a_obs;
      acc  = a_in_valid && a_in_ready;
      ret  = a_out_valid && a_out_ready;
      @(posedge clk);
      if (acc) begin
        expq.push_back(model16(vm[sent], ve[sent]));
        sent++;
      end
      occ = occ + int'(acc) - int'(ret);
      #1;
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    check("s_count", got, 8);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("s_drained", a_out_valid, 1'b0);
      @(posedge clk); #1;
    end

    // Reset with two operands in flight and the output stalled
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_mant_i = 16'h0001; a_exp_i = 5'd20;
    @(posedge clk); #1;
    a_mant_i = 16'h0010; a_exp_i = 5'd3;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    check("r_pre_vld", a_out_valid, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("r_vld", a_out_valid, 1'b0);
    check("r_obs", a_obs, 27'h0);
    check("r_rdy", a_in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    run16("r_new", 16'h0300, 5'd2, {16'h0C00, 5'd0, 4'd2, 1'b0, 1'b1});
    for (int i = 0; i < 4; i++) begin
      check("r_no_ghost", a_out_valid, 1'b0);
      @(posedge clk); #1;
    end

    // Single-bit sweep on the 32- and 64-bit instances, exponent at maximum
    for (int pos = 0; pos < 64; pos++) begin
      b_in_valid = (pos < 32);
      b_mant_i   = (pos < 32) ? (32'd1 << pos) : 32'd0;
      b_exp_i    = 8'hFF;
      c_in_valid = 1'b1;
      c_mant_i   = 64'd1 << pos;
      c_exp_i    = 8'hFF;
      #1;
      check("w64_rdy", c_in_ready, 1'b1);
      if (pos < 32) check("w32_rdy", b_in_ready, 1'b1);
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      c_in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      if (pos < 32) begin
        check("w32", {b_out_valid, b_mant_o, b_exp_o, b_shift, b_zero, b_uflow},
              {1'b1, 32'h8000_0000, 8'(255 - (31 - pos)), 5'(31 - pos), 1'b0, 1'b0});
      end
      check("w64_mant", c_mant_o, 64'h8000_0000_0000_0000);
      check("w64_ctl", {c_out_valid, c_exp_o, c_shift, c_zero, c_uflow},
            {1'b1, 8'(255 - (63 - pos)), 6'(63 - pos), 1'b0, 1'b0});
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
